// File: rtl/xunit_sha256_sched_if.sv
// ----------------------------------------------------------------------------
// xunit_sha256_sched_if
// Bundle of the run/done control, the 16 message-block words and the two
// output streams of the SHA-256 message-schedule producer.
//
// Handshake: run is a single-cycle start pulse, sampled on the rising edge of
// clk, and it restarts the unit whenever it is high. done is high while the
// unit is idle or the schedule has completed. There is no backpressure: after
// run, the words appear on out0/out1 at a fixed, configDelay-dependent cycle.
//
// Signals:
//   run          master->slave  start pulse
//   configDelay  master->slave  cycles from run to block load (8 bits)
//   in0..in15    master->slave  message block words M[0]..M[15]
//   done         slave->master  idle / schedule complete
//   out0         slave->master  schedule word W[t]
//   out1         slave->master  round constant K[t] (0 when feature is off)
// ----------------------------------------------------------------------------
interface xunit_sha256_sched_if #(
    parameter int DATA_W = 32
);
    logic              run;
    logic              done;
    logic [7:0]        configDelay;
    logic [DATA_W-1:0] in0, in1, in2, in3, in4, in5, in6, in7;
    logic [DATA_W-1:0] in8, in9, in10, in11, in12, in13, in14, in15;
    logic [DATA_W-1:0] out0;
    logic [DATA_W-1:0] out1;

    modport master (
        output run, configDelay,
        output in0, in1, in2, in3, in4, in5, in6, in7,
        output in8, in9, in10, in11, in12, in13, in14, in15,
        input  done, out0, out1
    );

    modport slave (
        input  run, configDelay,
        input  in0, in1, in2, in3, in4, in5, in6, in7,
        input  in8, in9, in10, in11, in12, in13, in14, in15,
        output done, out0, out1
    );
endinterface

// File: rtl/xunit_sha256_sched.sv
// ----------------------------------------------------------------------------
// xunit_sha256_sched
// SHA-256 message-schedule producer. Loads one 512-bit block as 16 words and
// then streams W[0..63] on out0, one word per cycle. Uses the same
// run/done/configDelay timing as the compression-round unit, so with equal
// configDelay W[t] lines up with round t.
//
// Ports:
//   clk   clock
//   rst   asynchronous, active-high reset
//   bus   xunit_sha256_sched_if.slave (run, configDelay, in0..in15,
//         done, out0, out1)
//
// Optional feature (macro XUNIT_SHA256_SCHED_K_EN):
//   defined   -> out1 = K[cnt] from an internal 64x32 ROM while cnt<64, else 0
//   undefined -> no ROM, out1 tied to 0
// ----------------------------------------------------------------------------
module xunit_sha256_sched #(
    parameter int DELAY_W = 10,
    parameter int DATA_W  = 32
) (
    input logic                  clk,
    input logic                  rst,
    xunit_sha256_sched_if.slave  bus
);

    // The delay counter only ever holds a configDelay value, so it never needs
    // more than 8 bits even though the template reserves DELAY_W.
    localparam int CNT_W = (DELAY_W < 8) ? DELAY_W : 8;

    logic [CNT_W-1:0]  delay;
    logic [6:0]        cnt;
    logic [DATA_W-1:0] r   [16];
    logic [DATA_W-1:0] blk [16];
    logic [DATA_W-1:0] w_next;
    logic              load;

    function automatic logic [DATA_W-1:0] sig0(input logic [DATA_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [DATA_W-1:0] sig1(input logic [DATA_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    always_comb begin
        blk[0]  = bus.in0;  blk[1]  = bus.in1;  blk[2]  = bus.in2;  blk[3]  = bus.in3;
        blk[4]  = bus.in4;  blk[5]  = bus.in5;  blk[6]  = bus.in6;  blk[7]  = bus.in7;
        blk[8]  = bus.in8;  blk[9]  = bus.in9;  blk[10] = bus.in10; blk[11] = bus.in11;
        blk[12] = bus.in12; blk[13] = bus.in13; blk[14] = bus.in14; blk[15] = bus.in15;
    end

    // The block is captured either on the run edge itself (zero delay) or on
    // the edge where the countdown leaves 1.
    assign load   = bus.run ? (bus.configDelay == 8'd0) : (delay == CNT_W'(1));

    // One 4-input adder chain produces W[t+16] from the sliding window.
    assign w_next = sig1(r[14]) + r[9] + sig0(r[1]) + r[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delay <= '0;
            cnt   <= 7'd64;
            for (int i = 0; i < 16; i++) r[i] <= '0;
        end else if (bus.run) begin
            delay <= CNT_W'(bus.configDelay);
            cnt   <= 7'd0;
            if (load) begin
                for (int i = 0; i < 16; i++) r[i] <= blk[i];
            end
        end else if (delay != '0) begin
            delay <= delay - CNT_W'(1);
            if (load) begin
                for (int i = 0; i < 16; i++) r[i] <= blk[i];
            end
        end else if (cnt < 7'd64) begin
            for (int i = 0; i < 15; i++) r[i] <= r[i+1];
            r[15] <= w_next;
            cnt   <= cnt + 7'd1;
        end
    end

    assign bus.done = (delay == '0) && (cnt == 7'd64);
    assign bus.out0 = r[0];

`ifdef XUNIT_SHA256_SCHED_K_EN
    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // cnt only spans 0..64, so bit 6 alone marks the finished state.
    assign bus.out1 = cnt[6] ? '0 : K_TAB[cnt[5:0]];
`else
    assign bus.out1 = '0;
`endif

endmodule

// File: tb/tb_xunit_sha256_sched.sv
module tb_xunit_sha256_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    xunit_sha256_sched_if #(.DATA_W(32)) bus ();

    xunit_sha256_sched #(.DELAY_W(10), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // exp_q[t] holds W[t] for t = 0..64 of the most recently loaded block.
    logic [31:0] exp_q[$];
    int m_wait = 0;
    int m_idx  = 64;
    bit m_cold = 1'b1;

    task automatic model_load();
        logic [31:0] w [65];
        w[0]  = bus.in0;  w[1]  = bus.in1;  w[2]  = bus.in2;  w[3]  = bus.in3;
        w[4]  = bus.in4;  w[5]  = bus.in5;  w[6]  = bus.in6;  w[7]  = bus.in7;
        w[8]  = bus.in8;  w[9]  = bus.in9;  w[10] = bus.in10; w[11] = bus.in11;
        w[12] = bus.in12; w[13] = bus.in13; w[14] = bus.in14; w[15] = bus.in15;
        for (int t = 16; t < 65; t++)
            w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
        exp_q.delete();
        for (int t = 0; t < 65; t++) exp_q.push_back(w[t]);
        m_cold = 1'b0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_wait = 0; m_idx = 64; m_cold = 1'b1; exp_q.delete();
        end else if (bus.run) begin
            m_idx = 0;
            if (bus.configDelay == 8'd0) begin
                model_load(); m_wait = 0;
            end else begin
                m_wait = bus.configDelay;
            end
        end else if (m_wait > 0) begin
            if (m_wait == 1) model_load();
            m_wait--;
        end else if (m_idx < 64) begin
            m_idx++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst) begin
            check("rst_done", bus.done, 32'd1);
            check("rst_out0", bus.out0, 32'd0);
            check("rst_out1", bus.out1, 32'd0);
        end else begin
            check("done", bus.done, (m_wait == 0 && m_idx == 64) ? 32'd1 : 32'd0);
            if (m_wait == 0) begin
                if (m_cold) check("idle_out0", bus.out0, 32'd0);
                else        check($sformatf("w[%0d]", m_idx), bus.out0, exp_q[m_idx]);
            end
`ifdef XUNIT_SHA256_SCHED_K_EN
            if (m_wait == 0 && m_idx == 64) check("k_done", bus.out1, 32'd0);
`else
            check("out1_zero", bus.out1, 32'd0);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_block(input logic [31:0] first, input logic [31:0] mid, input logic [31:0] last);
        bus.in0 = first;
        bus.in1 = mid;  bus.in2 = mid;  bus.in3 = mid;  bus.in4 = mid;
        bus.in5 = mid;  bus.in6 = mid;  bus.in7 = mid;  bus.in8 = mid;
        bus.in9 = mid;  bus.in10 = mid; bus.in11 = mid; bus.in12 = mid;
        bus.in13 = mid; bus.in14 = mid;
        bus.in15 = last;
    endtask

    task automatic scramble();
        bus.in0  = $urandom; bus.in1  = $urandom; bus.in2  = $urandom; bus.in3  = $urandom;
        bus.in4  = $urandom; bus.in5  = $urandom; bus.in6  = $urandom; bus.in7  = $urandom;
        bus.in8  = $urandom; bus.in9  = $urandom; bus.in10 = $urandom; bus.in11 = $urandom;
        bus.in12 = $urandom; bus.in13 = $urandom; bus.in14 = $urandom; bus.in15 = $urandom;
    endtask

    task automatic start(input logic [7:0] d);
        bus.configDelay = d;
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_len);
        int k = 0;
        while (!bus.done && k < 200) begin
            tick();
            k++;
        end
        check({name, "_done"}, bus.done, 32'd1);
        if (exp_len >= 0) check({name, "_len"}, k, exp_len);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.run = 1'b0;
        bus.configDelay = 8'd0;
        set_block(32'd0, 32'd0, 32'd0);

        // reset and idle
        rst = 1'b1;
        repeat (2) tick();
        check("reset_done", bus.done, 32'd1);
        check("reset_out0", bus.out0, 32'd0);
        check("reset_out1", bus.out1, 32'd0);
        rst = 1'b0;
        repeat (10) begin
            tick();
            check("idle_done", bus.done, 32'd1);
            check("idle_out0", bus.out0, 32'd0);
        end

        // "abc" block, configDelay = 3
        set_block(32'h61626380, 32'd0, 32'h00000018);
        start(8'd3);
        check("abc_done_low", bus.done, 32'd0);
        repeat (3) tick();
        check("abc_w0", bus.out0, 32'h61626380);
        check("model_w16", exp_q[16], 32'h61626380);
        check("model_w17", exp_q[17], 32'h000F0000);
        check("model_w18", exp_q[18], 32'h7DA86405);
        check("model_w19", exp_q[19], 32'h600003C6);
`ifdef XUNIT_SHA256_SCHED_K_EN
        check("abc_k0", bus.out1, 32'h428A2F98);
`endif
        scramble();  // block already captured; must not disturb the stream
        tick();
        check("abc_w1", bus.out0, 32'd0);
`ifdef XUNIT_SHA256_SCHED_K_EN
        check("abc_k1", bus.out1, 32'h71374491);
`endif
        repeat (15) tick();
        check("abc_w16", bus.out0, 32'h61626380);
        tick(); check("abc_w17", bus.out0, 32'h000F0000);
        tick(); check("abc_w18", bus.out0, 32'h7DA86405);
        tick(); check("abc_w19", bus.out0, 32'h600003C6);
        repeat (44) tick();
        check("abc_t63_busy", bus.done, 32'd0);
`ifdef XUNIT_SHA256_SCHED_K_EN
        check("abc_k63", bus.out1, 32'hC67178F2);
`endif
        tick();
        check("abc_t64_done", bus.done, 32'd1);
        check("abc_t64_out1", bus.out1, 32'd0);

        // same block, configDelay = 0
        set_block(32'h61626380, 32'd0, 32'h00000018);
        start(8'd0);
        check("d0_w0", bus.out0, 32'h61626380);
        scramble();
        wait_done("d0", 64);

        // restart mid-schedule with an all-ones block
        set_block(32'h61626380, 32'd0, 32'h00000018);
        start(8'd0);
        repeat (20) tick();
        set_block(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        start(8'd2);
        repeat (2) tick();
        check("rs_w0", bus.out0, 32'hFFFFFFFF);
        repeat (16) tick();
        check("rs_w16", bus.out0, 32'h203FFFFC);
        wait_done("rs", 48);

        // reset mid-schedule, then a cold start
        set_block(32'h61626380, 32'd0, 32'h00000018);
        start(8'd1);
        tick();
        check("mr_w0", bus.out0, 32'h61626380);
        repeat (30) tick();
        rst = 1'b1;
        #1;
        check("mr_done", bus.done, 32'd1);
        check("mr_out0", bus.out0, 32'd0);
        tick();
        rst = 1'b0;
        check("mr_after_done", bus.done, 32'd1);
        check("mr_after_out0", bus.out0, 32'd0);
        repeat (3) tick();
        set_block(32'h61626380, 32'd0, 32'h00000018);
        start(8'd3);
        repeat (3) tick();
        check("cold_w0", bus.out0, 32'h61626380);
        wait_done("cold", 64);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
